// File: rtl/ro_bus_capture_pkg.sv
// ro_pkg: shared sizing, the event record type and the gray-to-binary helper
// used by the readout-bus capture path.
//   N_CH       channels on the bus (gray bit k < N_CH owns channel k's slot)
//   GW         gray counter width
//   TS_W       timestamp width (low bits of the binary count)
//   FIFO_DEPTH event FIFO entries, power of 2
package ro_pkg;

    localparam int N_CH       = 8;
    localparam int GW         = 19;
    localparam int TS_W       = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int CH_W       = $clog2(N_CH);
    localparam int K_W        = $clog2(GW);

    typedef struct packed {
        logic [CH_W-1:0] chan;
        logic            pol;
        logic [TS_W-1:0] ts;
    } ro_event_t;

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ro_bus_capture_if.sv
// ro_bus_capture_if: gray counter + shared readout bus inputs and the event
// valid/ready stream.
//   master: drives gray, bus_eve, bus_pol_eve, ev_ready; observes ev_*
//   slave : the capture block; consumes bus, produces ev_valid/ev_chan/ev_pol/ev_ts
interface ro_bus_capture_if;
    import ro_pkg::*;

    logic [GW-1:0]   gray;
    logic            bus_eve;
    logic            bus_pol_eve;
    logic            ev_valid;
    logic            ev_ready;
    logic [CH_W-1:0] ev_chan;
    logic            ev_pol;
    logic [TS_W-1:0] ev_ts;

    modport master (
        output gray, bus_eve, bus_pol_eve, ev_ready,
        input  ev_valid, ev_chan, ev_pol, ev_ts
    );

    modport slave (
        input  gray, bus_eve, bus_pol_eve, ev_ready,
        output ev_valid, ev_chan, ev_pol, ev_ts
    );

endinterface

// File: rtl/ro_bus_capture_fifo.sv
// ro_event_fifo: synchronous first-word-fall-through FIFO of ro_event_t.
//   i_clk, i_reset  clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data  write request and record
//   i_pop           read request (ignored when empty)
//   o_data          head record (valid while !o_empty)
//   o_full, o_empty occupancy flags
// A push while full is accepted only when a pop frees the slot in the same cycle.
module ro_event_fifo
    import ro_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_push,
    input  ro_event_t i_data,
    input  logic      i_pop,
    output ro_event_t o_data,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    ro_event_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_wr_en;
    logic            w_rd_en;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !i_reset) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ro_bus_capture.sv
// ro_bus_capture: follows the master gray counter, decodes which channel owns
// each readout-bus slot, samples the shared bus one cycle after the slot is
// detected and queues {chan, pol, ts} records for the off-chip stream.
//   i_clk_master  master clock (same as the gray counter)
//   i_reset       synchronous active-high reset
//   i_en          capture enable (pops are still honoured when low)
//   ro_if         gray/bus inputs and ev_* valid/ready stream (slave side)
//   o_overflow    sticky: an event was dropped on a full FIFO
//   o_drop_cnt    dropped events, saturating at 255
//   o_gray_err    sticky: gray changed by more than one bit
module ro_bus_capture
    import ro_pkg::*;
(
    input  logic              i_clk_master,
    input  logic              i_reset,
    input  logic              i_en,
    ro_bus_capture_if.slave   ro_if,
    output logic              o_overflow,
    output logic [7:0]        o_drop_cnt,
    output logic              o_gray_err
);

    logic            r_primed;
    logic [GW-1:0]   r_gray_q;
    logic            r_slot_vld;
    logic [CH_W-1:0] r_slot_ch;
    logic [TS_W-1:0] r_slot_ts;

    logic [GW-1:0]   w_tog;
    logic [GW-1:0]   w_bin;
    logic            w_multi;
    logic            w_one_hot;
    logic [K_W-1:0]  w_k;
    logic            w_slot_hit;
    logic            w_bus_hit;
    logic            w_pol_hit;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;
    ro_event_t       w_ev;
    ro_event_t       w_head;

    // The first cycle after reset only captures the reference gray value, so
    // an arbitrary counter phase never shows up as a toggle.
    always_comb begin
        w_tog     = r_primed ? (ro_if.gray ^ r_gray_q) : '0;
        w_multi   = (w_tog & (w_tog - GW'(1))) != '0;
        w_one_hot = (w_tog != '0) && !w_multi;
        w_k       = '0;
        for (int i = 0; i < GW; i++) begin
            if (w_tog[i]) w_k = K_W'(i);
        end
        w_slot_hit = w_one_hot && (w_k < K_W'(N_CH));
        w_bin      = gray2bin(ro_if.gray);
    end

    // Only a solid 1 counts; an undriven or unknown line reads as no event.
    always_comb begin
        w_bus_hit = 1'b0;
        w_pol_hit = 1'b0;
        if (ro_if.bus_eve == 1'b1)     w_bus_hit = 1'b1;
        if (ro_if.bus_pol_eve == 1'b1) w_pol_hit = 1'b1;
    end

    assign w_push = r_slot_vld & i_en & w_bus_hit;
    assign w_pop  = ~w_empty & ro_if.ev_ready;
    assign w_drop = w_push & w_full & ~w_pop;
    assign w_ev   = '{chan: r_slot_ch, pol: w_pol_hit, ts: r_slot_ts};

    always_ff @(posedge i_clk_master) begin
        if (i_reset) begin
            r_primed   <= 1'b0;
            r_gray_q   <= '0;
            r_slot_vld <= 1'b0;
            r_slot_ch  <= '0;
            r_slot_ts  <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
            o_gray_err <= 1'b0;
        end else begin
            r_primed   <= 1'b1;
            r_gray_q   <= ro_if.gray;
            r_slot_vld <= w_slot_hit;
            if (w_slot_hit) begin
                r_slot_ch <= w_k[CH_W-1:0];
                r_slot_ts <= w_bin[TS_W-1:0];
            end
            if (w_multi) o_gray_err <= 1'b1;
            if (w_drop) begin
                o_overflow <= 1'b1;
                if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

    ro_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk_master),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  (w_ev),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Record fields read as zero whenever nothing is queued.
    assign ro_if.ev_valid = ~w_empty;
    assign ro_if.ev_chan  = w_empty ? '0 : w_head.chan;
    assign ro_if.ev_pol   = w_empty ? 1'b0 : w_head.pol;
    assign ro_if.ev_ts    = w_empty ? '0 : w_head.ts;

endmodule

// File: tb/tb_ro_bus_capture.sv
module tb_ro_bus_capture;
    import ro_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ovf;
    logic [7:0] dcnt;
    logic       gerr;

    ro_bus_capture_if ifc ();

    ro_bus_capture dut (
        .i_clk_master (clk),
        .i_reset      (rst),
        .i_en         (en),
        .ro_if        (ifc.slave),
        .o_overflow   (ovf),
        .o_drop_cnt   (dcnt),
        .o_gray_err   (gerr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model (event level) ----------------
    bit            m_primed, m_pend, m_ovf, m_gerr;
    int            m_pk, m_pts, m_drop;
    logic [GW-1:0] m_gq;
    ro_event_t     m_q[$];

    function automatic logic [GW-1:0] gc(int n);
        return GW'(n ^ (n >> 1));
    endfunction

    function automatic int g2b(int g);
        int b = g;
        for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_primed = 0; m_pend = 0; m_gq = '0; m_q.delete();
            m_ovf = 0; m_gerr = 0; m_drop = 0;
        end else begin
            bit pop, push;
            int tog, k;
            ro_event_t r;
            pop  = (m_q.size() > 0) && (ifc.ev_ready == 1'b1);
            push = m_pend && (en == 1'b1) && (ifc.bus_eve == 1'b1);
            if (push && m_q.size() == FIFO_DEPTH && !pop) begin
                push = 0; m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                r.chan = CH_W'(m_pk);
                r.pol  = ifc.bus_pol_eve;
                r.ts   = TS_W'(m_pts);
                m_q.push_back(r);
            end
            m_pend = 0;
            if (m_primed) begin
                tog = int'(ifc.gray ^ m_gq);
                if ($countones(tog) > 1) m_gerr = 1;
                else if (tog != 0) begin
                    k = $clog2(tog);
                    if (k < N_CH) begin
                        m_pend = 1; m_pk = k;
                        m_pts = g2b(int'(ifc.gray)) % (1 << TS_W);
                    end
                end
            end
            m_primed = 1;
            m_gq = ifc.gray;
        end
    endtask

    task automatic check_model();
        bit ok;
        ro_event_t exp_h;
        ok = 1;
        exp_h = (m_q.size() > 0) ? m_q[0] : '0;
        if (ifc.ev_valid !== (m_q.size() > 0)) ok = 0;
        if (m_q.size() > 0 && {ifc.ev_chan, ifc.ev_pol, ifc.ev_ts} !== exp_h) ok = 0;
        if (ovf !== m_ovf || gerr !== m_gerr || dcnt !== 8'(m_drop)) ok = 0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL model t=%0t: got valid=%b head=%h ovf=%b drop=%0d gerr=%b, required valid=%b head=%h ovf=%b drop=%0d gerr=%b",
                     $time, ifc.ev_valid, {ifc.ev_chan, ifc.ev_pol, ifc.ev_ts}, ovf, dcnt, gerr,
                     m_q.size() > 0, exp_h, m_ovf, m_drop, m_gerr);
        end
    endtask

    task automatic drv(logic r, logic [GW-1:0] g, logic be, logic bp, logic e, logic rdy);
        rst = r; ifc.gray = g; ifc.bus_eve = be; ifc.bus_pol_eve = bp;
        en = e; ifc.ev_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic chk(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst; int cnt; logic be, bp, rdy;
        logic ev; int ch; logic pl; int ts;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int n;
        logic [GW-1:0] g;

        tbl[0] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[1] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[2] = '{1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[3] = '{1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[4] = '{1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[5] = '{1'b0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0};
        tbl[6] = '{1'b0, 5, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1, 4};
        tbl[7] = '{1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 4};
        tbl[8] = '{1'b0, 7, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};
        tbl[9] = '{1'b0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0};

        // Free run with an idle bus: nothing captured, no flags.
        drv(1, '0, 0, 0, 1, 1);
        chk("reset_valid", int'(ifc.ev_valid), 0);
        chk("reset_drop", int'(dcnt), 0);
        for (int i = 0; i < 1024; i++) drv(0, gc(i), 0, 0, 1, 1);
        chk("idle_valid", int'(ifc.ev_valid), 0);
        chk("idle_gerr", int'(gerr), 0);
        chk("idle_ovf", int'(ovf), 0);

        // Single event in the slot of count 4 (bit 2).
        foreach (tbl[i]) begin
            drv(tbl[i].rst, gc(tbl[i].cnt), tbl[i].be, tbl[i].bp, 1, tbl[i].rdy);
            chk("tbl_valid", int'(ifc.ev_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_chan", int'(ifc.ev_chan), tbl[i].ch);
                chk("tbl_pol", int'(ifc.ev_pol), int'(tbl[i].pl));
                chk("tbl_ts", int'(ifc.ev_ts), tbl[i].ts);
            end
        end

        // Nine events into a stalled 8-deep FIFO, then drain.
        drv(1, '0, 0, 0, 1, 0);
        drv(0, gc(0), 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) drv(0, gc(i), logic'(i >= 2), logic'(i % 2), 1, 0);
        chk("full_ovf", int'(ovf), 1);
        chk("full_drop", int'(dcnt), 1);
        chk("full_head_ts", int'(ifc.ev_ts), 1);
        for (int i = 11; i <= 20; i++) drv(0, gc(i), 0, 0, 1, 1);
        chk("drained_valid", int'(ifc.ev_valid), 0);
        chk("drained_drop_sticky", int'(dcnt), 1);

        // Two-bit gray step is an error and yields no slot.
        drv(1, '0, 0, 0, 1, 0);
        drv(0, GW'(0), 0, 0, 1, 0);
        drv(0, GW'(3), 1, 1, 1, 0);
        drv(0, GW'(3), 1, 1, 1, 0);
        chk("gerr_set", int'(gerr), 1);
        chk("gerr_no_rec", int'(ifc.ev_valid), 0);
        drv(0, gc(3), 0, 0, 1, 0);
        drv(0, gc(4), 1, 0, 1, 0);
        chk("gerr_resume_valid", int'(ifc.ev_valid), 1);
        chk("gerr_resume_ts", int'(ifc.ev_ts), 3);
        chk("gerr_resume_chan", int'(ifc.ev_chan), 0);

        // Reset in the middle of a drain.
        drv(1, '0, 0, 0, 1, 0);
        drv(0, gc(0), 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) drv(0, gc(i), logic'(i >= 2), 1, 1, 0);
        chk("pre_rst_valid", int'(ifc.ev_valid), 1);
        drv(0, gc(5), 0, 0, 1, 1);
        drv(1, gc(6), 1, 1, 1, 1);
        chk("midrst_valid", int'(ifc.ev_valid), 0);
        chk("midrst_drop", int'(dcnt), 0);
        drv(0, gc(7), 1, 1, 1, 1);
        drv(0, gc(8), 1, 1, 1, 1);
        chk("post_rst_no_rec", int'(ifc.ev_valid), 0);

        // Slot of bit 8 is outside the channel range; en=0 blocks capture.
        drv(1, '0, 0, 0, 1, 1);
        drv(0, gc(255), 0, 0, 1, 1);
        drv(0, gc(256), 0, 0, 1, 1);
        drv(0, gc(257), 1, 1, 1, 1);
        chk("bit8_no_rec", int'(ifc.ev_valid), 0);
        drv(0, gc(258), 1, 1, 0, 1);
        chk("en0_no_rec", int'(ifc.ev_valid), 0);

        // Random traffic across the counter wrap.
        drv(1, '0, 0, 0, 1, 0);
        n = (1 << GW) - 700;
        for (int i = 0; i < 1500; i++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) begin
                g = GW'($urandom);
                n = g2b(int'(g));
            end else begin
                if ($urandom_range(0, 15) != 0) n = (n + 1) % (1 << GW);
                g = gc(n);
            end
            drv(r, g, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
